program_memory_loader: RTL

//  Writer side of the program-memory interface: receives a byte stream (e.g. from a UART RX) and

---
 rtl/program_memory_loader.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/program_memory_loader.sv
// Program memory loader: turns an incoming byte stream into 32-bit instruction
// words written to program memory, and holds the core in reset until a complete
// image has arrived.
// Image layout: LEN_LO, LEN_HI (word count, little-endian), then each word as
// 4 little-endian bytes.
// Optional feature: define PROGRAM_MEMORY_LOADER_CHECKSUM_EN to expect one
// trailing byte equal to the modulo-256 sum of all data bytes.
module program_memory_loader #(
    parameter int unsigned PROGRAM_MEMORY_DEPTH = 64,
    parameter logic [31:0] BASE_ADDRESS         = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        Mem_Write_o,
    output logic [31:0] Mem_Address_o,
    output logic [31:0] Mem_Data_o,
    output logic        Core_Reset_o,
    output logic        Done_o,
    output logic        Error_o
);

`ifdef PROGRAM_MEMORY_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHK, ST_DONE, ST_ERROR
    } state_t;
    localparam state_t AFTER_IMAGE = ST_CHK;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_DONE, ST_ERROR
    } state_t;
    localparam state_t AFTER_IMAGE = ST_DONE;
`endif

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  len_lo_q;
    logic [15:0] word_count_q;
    logic [15:0] word_index_q;
    logic [1:0]  byte_count_q;
    logic [23:0] shift_q;
`ifdef PROGRAM_MEMORY_LOADER_CHECKSUM_EN
    logic [7:0]  checksum_q;
`endif

    logic        accept;
    logic        start_taken;
    logic [15:0] len_value;
    logic        len_too_big;
    logic        word_complete;
    logic        last_word;

    assign accept        = rx_valid_i & rx_ready_o;
    assign start_taken   = start_i & ((state_q == ST_IDLE) | (state_q == ST_DONE) |
                                      (state_q == ST_ERROR));
    assign len_value     = {rx_data_i, len_lo_q};
    assign len_too_big   = {16'd0, len_value} > 32'(PROGRAM_MEMORY_DEPTH);
    assign word_complete = accept & (state_q == ST_DATA) & (byte_count_q == 2'd3);
    assign last_word     = (word_index_q + 16'd1) == word_count_q;

`ifdef PROGRAM_MEMORY_LOADER_CHECKSUM_EN
    assign rx_ready_o = (state_q == ST_LEN_LO) | (state_q == ST_LEN_HI) |
                        (state_q == ST_DATA)   | (state_q == ST_CHK);
`else
    assign rx_ready_o = (state_q == ST_LEN_LO) | (state_q == ST_LEN_HI) |
                        (state_q == ST_DATA);
`endif
    assign Done_o       = (state_q == ST_DONE);
    assign Error_o      = (state_q == ST_ERROR);
    assign Core_Reset_o = (state_q == ST_DONE);

    // State register; reset parks the loader in IDLE with the core held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode: walk the image header, data words and optional checksum.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_LEN_LO;
            ST_LEN_LO: if (accept) state_d = ST_LEN_HI;
            ST_LEN_HI: begin
                if (accept) begin
                    if (len_value == 16'd0) state_d = AFTER_IMAGE;
                    else if (len_too_big)   state_d = ST_ERROR;
                    else                    state_d = ST_DATA;
                end
            end
            ST_DATA:   if (word_complete && last_word) state_d = AFTER_IMAGE;
`ifdef PROGRAM_MEMORY_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) state_d = (rx_data_i == checksum_q) ? ST_DONE : ST_ERROR;
            end
`endif
            ST_DONE:   if (start_i) state_d = ST_LEN_LO;
            ST_ERROR:  if (start_i) state_d = ST_LEN_LO;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath: capture length, assemble words and issue the one-cycle write strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_lo_q      <= 8'd0;
            word_count_q  <= 16'd0;
            word_index_q  <= 16'd0;
            byte_count_q  <= 2'd0;
            shift_q       <= 24'd0;
`ifdef PROGRAM_MEMORY_LOADER_CHECKSUM_EN
            checksum_q    <= 8'd0;
`endif
            Mem_Write_o   <= 1'b0;
            Mem_Address_o <= BASE_ADDRESS;
            Mem_Data_o    <= 32'd0;
        end else begin
            Mem_Write_o <= 1'b0;
            if (start_taken) begin
                word_index_q <= 16'd0;
                byte_count_q <= 2'd0;
`ifdef PROGRAM_MEMORY_LOADER_CHECKSUM_EN
                checksum_q   <= 8'd0;
`endif
            end
            if (accept) begin
                case (state_q)
                    ST_LEN_LO: len_lo_q <= rx_data_i;
                    ST_LEN_HI: begin
                        word_count_q <= len_value;
                        word_index_q <= 16'd0;
                        byte_count_q <= 2'd0;
                    end
                    ST_DATA: begin
`ifdef PROGRAM_MEMORY_LOADER_CHECKSUM_EN
                        checksum_q <= checksum_q + rx_data_i;
`endif
                        if (byte_count_q == 2'd3) begin
                            Mem_Write_o   <= 1'b1;
                            Mem_Data_o    <= {rx_data_i, shift_q};
                            Mem_Address_o <= BASE_ADDRESS + {14'd0, word_index_q, 2'b00};
                            word_index_q  <= word_index_q + 16'd1;
                            byte_count_q  <= 2'd0;
                        end else begin
                            shift_q      <= {rx_data_i, shift_q[23:8]};
                            byte_count_q <= byte_count_q + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
